// File: rtl/hazard_ctrl.sv
// Front-end sequencing controller: load-use stalls, post-redirect nop bubbles, break parking.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_in,
    input  logic [4:0]       id_rt_in,
    input  logic             id_uses_rs_in,
    input  logic             id_uses_rt_in,
    input  logic             ex_mem_re_in,
    input  logic [4:0]       ex_rd_in,
    input  logic             redirect_in,
    input  logic             halt_in,
    output logic             pc_en_out,
    output logic             fd_en_out,
    output logic             nop_sel_out,
    output logic             flush_out,
    output logic             halted_out,
    output logic [CNT_W-1:0] stall_cnt_out,
    output logic [CNT_W-1:0] flush_cnt_out
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    localparam logic [3:0] FRELOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [3:0] fcnt;
    logic       hz;
    logic       stall_ev;
    logic       flush_ev;

    assign hz = ex_mem_re_in && (ex_rd_in != 5'd0) &&
                ((id_uses_rs_in && (id_rs_in == ex_rd_in)) ||
                 (id_uses_rt_in && (id_rt_in == ex_rd_in)));

    always_comb begin
        pc_en_out   = 1'b0;
        fd_en_out   = 1'b0;
        nop_sel_out = 1'b1;
        flush_out   = 1'b0;
        halted_out  = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (redirect_in) begin
                        pc_en_out = 1'b1;
                        fd_en_out = 1'b1;
                        flush_out = 1'b1;
                        flush_ev  = 1'b1;
                    end else if (halt_in) begin
                        nop_sel_out = 1'b1;
                    end else if (hz) begin
                        // Hold PC and IF/ID; the bubble goes into EX, not decode.
                        nop_sel_out = 1'b0;
                        flush_out   = 1'b1;
                        stall_ev    = 1'b1;
                    end else begin
                        pc_en_out   = 1'b1;
                        fd_en_out   = 1'b1;
                        nop_sel_out = 1'b0;
                    end
                end
                FLUSH: begin
                    pc_en_out = 1'b1;
                    fd_en_out = 1'b1;
                    if (redirect_in) begin
                        flush_out = 1'b1;
                        flush_ev  = 1'b1;
                    end
                end
                HALT: halted_out = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            fcnt  <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_in) begin
                        state <= (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                        fcnt  <= FRELOAD;
                    end else if (halt_in) begin
                        state <= HALT;
                    end
                end
                FLUSH: begin
                    if (redirect_in) begin
                        state <= (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                        fcnt  <= FRELOAD;
                    end else begin
                        fcnt <= fcnt - 4'd1;
                        if (fcnt <= 4'd1) state <= RUN;
                    end
                end
                HALT: state <= HALT;
                default: begin
                    state <= RUN;
                    fcnt  <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating: a counter parked at all-ones stays there until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_out = stall_cnt;
    assign flush_cnt_out = flush_cnt;
`else
    logic unused_ev;
    assign unused_ev     = stall_ev ^ flush_ev;
    assign stall_cnt_out = '0;
    assign flush_cnt_out = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed sequences plus random traffic against a bubble-count model.
module tb_hazard_ctrl;
    localparam int FC    = 2;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic id_uses_rs = 0, id_uses_rt = 0, ex_mem_re = 0, redirect = 0, halt = 0;
    logic pc_en, fd_en, nop_sel, flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Model: halted flag, number of bubble cycles still owed after this one, event counts.
    bit m_halt = 0;
    int m_rem  = 0;
    int m_sc   = 0;
    int m_fc   = 0;
    bit m_cv   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs_in(id_rs), .id_rt_in(id_rt),
        .id_uses_rs_in(id_uses_rs), .id_uses_rt_in(id_uses_rt),
        .ex_mem_re_in(ex_mem_re), .ex_rd_in(ex_rd),
        .redirect_in(redirect), .halt_in(halt),
        .pc_en_out(pc_en), .fd_en_out(fd_en), .nop_sel_out(nop_sel),
        .flush_out(flush), .halted_out(halted),
        .stall_cnt_out(stall_cnt), .flush_cnt_out(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic rst = 0, input logic rdr = 0, input logic hlt = 0,
                        input logic re = 0, input logic [4:0] rd = 0, input logic [4:0] rs = 0,
                        input logic [4:0] rt = 0, input logic urs = 0, input logic urt = 0);
        bit e_pc, e_fd, e_nop, e_fl, e_h, is_hz;
        @(negedge clk);
        reset = rst; redirect = rdr; halt = hlt; ex_mem_re = re; ex_rd = rd;
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        #1;
        is_hz = re && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
        {e_pc, e_fd, e_nop, e_fl, e_h} = 5'b00100;
        if (rst)             ;
        else if (m_halt)     e_h = 1;
        else if (rdr)        {e_pc, e_fd, e_fl} = 3'b111;
        else if (m_rem > 0)  {e_pc, e_fd} = 2'b11;
        else if (hlt)        ;
        else if (is_hz)      {e_nop, e_fl} = 2'b01;
        else                 {e_pc, e_fd, e_nop} = 3'b110;
        chk("pc_en", pc_en, e_pc);
        chk("fd_en", fd_en, e_fd);
        chk("nop_sel", nop_sel, e_nop);
        chk("flush", flush, e_fl);
        chk("halted", halted, e_h);
        if (m_cv && !rst) begin
            chk("stall_cnt", stall_cnt, PERF ? m_sc : 0);
            chk("flush_cnt", flush_cnt, PERF ? m_fc : 0);
        end
        if (rst) begin
            m_halt = 0; m_rem = 0; m_sc = 0; m_fc = 0; m_cv = 1;
        end else if (m_halt) ;
        else if (rdr) begin
            m_rem = FC - 1;
            if (m_fc < CMAX) m_fc++;
        end else if (m_rem > 0) m_rem--;
        else if (hlt) m_halt = 1;
        else if (is_hz) begin
            if (m_sc < CMAX) m_sc++;
        end
    endtask

    initial begin
        // Reset, then first running cycle
        tick(1); tick(1);
        tick(); tick();
        // Load-use on rs, then on rt, then ex_rd=0 and a non-load
        tick(0, 0, 0, 1, 8, 8, 0, 1, 0);
        tick();
        tick(0, 0, 0, 1, 9, 3, 9, 0, 1);
        tick(0, 0, 0, 1, 0, 0, 0, 1, 1);
        tick(0, 0, 0, 0, 8, 8, 8, 1, 1);
        tick(0, 0, 0, 1, 8, 8, 0, 0, 0);
        tick();
        // Redirect pulse, two bubble cycles
        tick(0, 1); tick(); tick(); tick();
        // Redirect re-armed on the second bubble cycle
        tick(0, 1); tick(0, 1); tick(); tick(); tick();
        // Redirect beats halt; hazard and halt ignored during flush
        tick(0, 1, 1); tick(0, 0, 1, 1, 8, 8, 0, 1, 0); tick(); tick();
        // Halt held 20 cycles with redirect and hazards present
        tick(0, 0, 1);
        for (int i = 0; i < 20; i++) tick(0, i[0], 0, 1, 5, 5, 5, 1, 1);
        // Reset out of HALT, and reset mid-flush
        tick(1); tick(); tick();
        tick(0, 1); tick(1); tick(); tick();
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd, rs, rt;
            rd = 5'($urandom_range(0, 3)); rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
            tick($urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0,
                 1'($urandom), rd, rs, rt, 1'($urandom), 1'($urandom));
        end
        // Drive the stall counter into saturation
        tick(1);
        for (int i = 0; i < CMAX + 4; i++) tick(0, 0, 0, 1, 8, 8, 0, 1, 0);
        tick(); tick(0, 1); tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
